// File: rtl/pipe_step_ctrl_pkg.sv
// Shared types and default constants for the pipeline step controller.
package pipe_ctrl_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Defaults sized for a 50 MHz board clock.
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_RUN_DIV         = 25000000;
    localparam int DEF_CNT_W           = 8;
    localparam int DEF_PC_W            = 32;

    // Width of a counter that must hold the values 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_step_ctrl_if.sv
// Board-side signal bundle of the step controller: buttons, breakpoint
// inputs and the pipeline/LCD-facing outputs.
interface pipe_step_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PC_W  = DEF_PC_W
);
    logic             btn_step;
    logic             btn_run;
    logic             clr;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  break_pc;
    logic             break_en;
    logic             step_en;
    logic             refresh;
    logic [CNT_W-1:0] cycle_cnt;
    logic             running;
    logic             halted;

    // Board / environment side.
    modport master (
        output btn_step, btn_run, clr, pc, break_pc, break_en,
        input  step_en, refresh, cycle_cnt, running, halted
    );

    // Controller side.
    modport slave (
        input  btn_step, btn_run, clr, pc, break_pc, break_en,
        output step_en, refresh, cycle_cnt, running, halted
    );
endinterface

// File: rtl/pipe_step_ctrl_btn_debounce.sv
// Raw button front end: 2-FF synchronizer, stability filter and registered
// rising-edge detector on the filtered level.
module btn_debounce
    import pipe_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q,      sync_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          level_q,     level_d;
    logic          level_dly_q, level_dly_d;
    logic          rise_q,      rise_d;

    // Next-state: shift the synchronizer, count cycles of disagreement, flip
    // the accepted level after DEBOUNCE_CYCLES of them, and flag a 0->1 change.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        sync_d      = {sync_q[0], btn};
        cnt_d       = cnt_q;
        level_d     = level_q;
        level_dly_d = level_q;
        rise_d      = level_q & ~level_dly_q;
        if (sync_q[1] == level_q) begin
            // Agreement (or a bounce back) restarts the stability window.
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Filter and synchronizer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            rise_q      <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/pipe_step_ctrl.sv
// Clock-enable sequencer for the teaching pipeline: turns debounced button
// presses into single step_en pulses, or free-runs at RUN_DIV cycles per step
// with an optional PC breakpoint, and keeps the step counter and LCD strobe.
module pipe_step_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RUN_DIV         = DEF_RUN_DIV,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int PC_W            = DEF_PC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_step_ctrl_if.slave   bus
);
    localparam int PW = cnt_width(RUN_DIV);

    logic [1:0]       rst_pipe_q, rst_pipe_d;
    logic             rst_sync_n;
    logic             step_level, run_level;
    logic             step_pulse, run_pulse;
    logic             unused_levels;

    state_e           state_q,   state_d;
    logic [PW-1:0]    presc_q,   presc_d;
    logic             skip_bp_q, skip_bp_d;
    logic             step_en_q, step_en_d;
    logic             refresh_q, refresh_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             presc_tc;
    logic             bp_hit;

    // Reset release ordering: assertion is immediate, deassertion lands on a clock edge.
    assign rst_pipe_d = {rst_pipe_q[0], 1'b1};

    // Reset synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe_q <= '0;
        end else begin
            rst_pipe_q <= rst_pipe_d;
        end
    end

    assign rst_sync_n = rst_pipe_q[1];

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk   (clk),
        .rst_n (rst_sync_n),
        .btn   (bus.btn_step),
        .level (step_level),
        .rise  (step_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk   (clk),
        .rst_n (rst_sync_n),
        .btn   (bus.btn_run),
        .level (run_level),
        .rise  (run_pulse)
    );

    // Only the press edges drive the sequencer; the held levels are not needed here.
    assign unused_levels = step_level ^ run_level;

    assign presc_tc = (presc_q == PW'(RUN_DIV - 1));
    assign bp_hit   = bus.break_en && (PC_W'(bus.pc) == PC_W'(bus.break_pc));

    // Next-state and step decision; priority is clr, then run press, then step press.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        skip_bp_d = skip_bp_q;
        step_en_d = 1'b0;
        cnt_d     = cnt_q;
        if (bus.clr) begin
            state_d   = ST_IDLE;
            presc_d   = '0;
            skip_bp_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (run_pulse) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end else if (step_pulse) begin
                        step_en_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_pulse) begin
                        state_d = ST_IDLE;
                        presc_d = '0;
                    end else if (presc_tc) begin
                        presc_d = '0;
                        if (bp_hit && !skip_bp_q) begin
                            state_d = ST_HALT;
                        end else begin
                            step_en_d = 1'b1;
                            skip_bp_d = 1'b0;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                ST_HALT: begin
                    if (run_pulse) begin
                        // Resume must be able to step off the breakpoint PC.
                        state_d   = ST_RUN;
                        presc_d   = '0;
                        skip_bp_d = 1'b1;
                    end else if (step_pulse) begin
                        state_d   = ST_IDLE;
                        step_en_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end
            endcase
        end
        if (bus.clr) begin
            cnt_d = '0;
        end else if (step_en_d) begin
            cnt_d = cnt_q + 1'b1;
        end
        refresh_d = step_en_q | bus.clr;
    end

    // Controller state, prescaler, counter and output registers.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            skip_bp_q <= 1'b0;
            step_en_q <= 1'b0;
            refresh_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            skip_bp_q <= skip_bp_d;
            step_en_q <= step_en_d;
            refresh_q <= refresh_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.step_en   = step_en_q;
    assign bus.refresh   = refresh_q;
    assign bus.cycle_cnt = cnt_q;
    assign bus.running   = (state_q == ST_RUN);
    assign bus.halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Directed bench for pipe_step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=8.
module tb_pipe_step_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   step_seen;
    logic prev_step;

    pipe_step_ctrl_if #(.CNT_W(8), .PC_W(32)) bus ();

    pipe_step_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .RUN_DIV         (8),
        .CNT_W           (8),
        .PC_W            (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts issued steps and flags any two-cycle step_en.
    always @(posedge clk) begin
        #1;
        if (bus.step_en === 1'b1) begin
            step_seen++;
            total++;
            if (prev_step === 1'b1) begin
                bad++;
                $display("FAIL step_back_to_back got=11 exp=not two in a row");
            end
        end
        prev_step = bus.step_en;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        tick(3);
        total++; if (bus.step_en !== 1'b0)    begin bad++; $display("FAIL rst_step_en got=%0b exp=0", bus.step_en); end
        total++; if (bus.refresh !== 1'b0)    begin bad++; $display("FAIL rst_refresh got=%0b exp=0", bus.refresh); end
        total++; if (bus.cycle_cnt !== 8'd0)  begin bad++; $display("FAIL rst_cycle_cnt got=%0h exp=0", bus.cycle_cnt); end
        total++; if (bus.running !== 1'b0)    begin bad++; $display("FAIL rst_running got=%0b exp=0", bus.running); end
        total++; if (bus.halted !== 1'b0)     begin bad++; $display("FAIL rst_halted got=%0b exp=0", bus.halted); end
        rst_n = 1'b1;
        tick(6);
        total++; if (bus.running !== 1'b0 || bus.step_en !== 1'b0) begin
            bad++; $display("FAIL post_rst_idle got=run%0b/step%0b exp=0/0", bus.running, bus.step_en);
        end
    endtask

    task automatic test_step_press();
        int c0;
        c0 = step_seen;
        bus.btn_step = 1'b1;
        tick(7);
        total++; if (step_seen !== c0 || bus.step_en !== 1'b0) begin
            bad++; $display("FAIL step_early got=%0d steps exp=0", step_seen - c0);
        end
        tick(1);
        total++; if (bus.step_en !== 1'b1)   begin bad++; $display("FAIL step_latency got=%0b exp=1", bus.step_en); end
        total++; if (bus.cycle_cnt !== 8'd1) begin bad++; $display("FAIL step_cnt got=%0d exp=1", bus.cycle_cnt); end
        tick(1);
        total++; if (bus.refresh !== 1'b1)   begin bad++; $display("FAIL step_refresh got=%0b exp=1", bus.refresh); end
        tick(11);
        bus.btn_step = 1'b0;
        tick(15);
        total++; if (step_seen !== c0 + 1)   begin bad++; $display("FAIL step_once got=%0d exp=1", step_seen - c0); end
    endtask

    task automatic test_bounce();
        int c0;
        c0 = step_seen;
        bus.btn_step = 1'b1; tick(2);
        bus.btn_step = 1'b0; tick(2);
        bus.btn_step = 1'b1; tick(2);
        bus.btn_step = 1'b0; tick(2);
        bus.btn_step = 1'b1;
        tick(7);
        total++; if (step_seen !== c0)       begin bad++; $display("FAIL bounce_early got=%0d exp=0", step_seen - c0); end
        tick(1);
        total++; if (bus.step_en !== 1'b1)   begin bad++; $display("FAIL bounce_step got=%0b exp=1", bus.step_en); end
        total++; if (bus.cycle_cnt !== 8'd2) begin bad++; $display("FAIL bounce_cnt got=%0d exp=2", bus.cycle_cnt); end
        tick(10);
        bus.btn_step = 1'b0;
        tick(15);
        total++; if (step_seen !== c0 + 1)   begin bad++; $display("FAIL bounce_once got=%0d exp=1", step_seen - c0); end
    endtask

    task automatic test_run();
        int c0;
        c0 = step_seen;
        bus.btn_run = 1'b1;
        tick(7);
        total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL run_early got=%0b exp=0", bus.running); end
        tick(1);
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL run_enter got=%0b exp=1", bus.running); end
        bus.btn_run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(7);
            total++; if (step_seen !== c0 + k) begin bad++; $display("FAIL run_gap%0d got=%0d exp=%0d", k, step_seen - c0, k); end
            tick(1);
            total++; if (bus.step_en !== 1'b1) begin bad++; $display("FAIL run_step%0d got=%0b exp=1", k, bus.step_en); end
        end
        // Stop press lands on the cycle the prescaler wraps: the stop must win.
        bus.btn_run = 1'b1;
        tick(7);
        total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL run_hold got=%0b exp=1", bus.running); end
        tick(1);
        total++; if (bus.running !== 1'b0 || bus.step_en !== 1'b0) begin
            bad++; $display("FAIL run_stop got=run%0b/step%0b exp=0/0", bus.running, bus.step_en);
        end
        bus.btn_run = 1'b0;
        tick(20);
        total++; if (step_seen !== c0 + 4)   begin bad++; $display("FAIL run_total got=%0d exp=4", step_seen - c0); end
        total++; if (bus.cycle_cnt !== 8'd6) begin bad++; $display("FAIL run_cnt got=%0d exp=6", bus.cycle_cnt); end
    endtask

    task automatic test_breakpoint();
        int c0;
        c0 = step_seen;
        bus.pc = 32'h0;
        bus.break_pc = 32'h0C;
        bus.break_en = 1'b1;
        bus.btn_run = 1'b1;
        tick(8);
        bus.btn_run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(8);
            total++; if (bus.step_en !== 1'b1) begin bad++; $display("FAIL bp_step%0d got=%0b exp=1", k, bus.step_en); end
            bus.pc = bus.pc + 32'd4;
        end
        tick(8);
        total++; if (bus.halted !== 1'b1 || bus.running !== 1'b0) begin
            bad++; $display("FAIL bp_halt got=halt%0b/run%0b exp=1/0", bus.halted, bus.running);
        end
        total++; if (bus.step_en !== 1'b0)   begin bad++; $display("FAIL bp_no_step got=%0b exp=0", bus.step_en); end
        tick(12);
        total++; if (step_seen !== c0 + 3 || bus.cycle_cnt !== 8'd9) begin
            bad++; $display("FAIL bp_hold got=%0d/%0d exp=3/9", step_seen - c0, bus.cycle_cnt);
        end
        bus.btn_run = 1'b1;
        tick(8);
        total++; if (bus.halted !== 1'b0 || bus.running !== 1'b1) begin
            bad++; $display("FAIL bp_resume got=halt%0b/run%0b exp=0/1", bus.halted, bus.running);
        end
        bus.btn_run = 1'b0;
        tick(8);
        total++; if (bus.step_en !== 1'b1 || bus.cycle_cnt !== 8'd10) begin
            bad++; $display("FAIL bp_leave got=step%0b/cnt%0d exp=1/10", bus.step_en, bus.cycle_cnt);
        end
        bus.pc = 32'h10;
        bus.btn_run = 1'b1;
        tick(8);
        total++; if (bus.running !== 1'b0 || bus.cycle_cnt !== 8'd10) begin
            bad++; $display("FAIL bp_stop got=run%0b/cnt%0d exp=0/10", bus.running, bus.cycle_cnt);
        end
        bus.btn_run = 1'b0;
        tick(15);
    endtask

    task automatic test_wrap_and_clr();
        int c0;
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        total++; if (bus.refresh !== 1'b1 || bus.cycle_cnt !== 8'd0) begin
            bad++; $display("FAIL clr_basic got=ref%0b/cnt%0d exp=1/0", bus.refresh, bus.cycle_cnt);
        end
        // Breakpoint match present but manual steps must ignore it.
        bus.pc = 32'h0C;
        c0 = step_seen;
        for (int i = 0; i < 256; i++) begin
            bus.btn_step = 1'b1; tick(10);
            bus.btn_step = 1'b0; tick(10);
            if (i == 254) begin
                total++; if (bus.cycle_cnt !== 8'hFF) begin bad++; $display("FAIL wrap_ff got=%0h exp=ff", bus.cycle_cnt); end
            end
        end
        total++; if (bus.cycle_cnt !== 8'h00)  begin bad++; $display("FAIL wrap_00 got=%0h exp=00", bus.cycle_cnt); end
        total++; if (step_seen !== c0 + 256)   begin bad++; $display("FAIL wrap_steps got=%0d exp=256", step_seen - c0); end
        bus.btn_step = 1'b1; tick(10);
        bus.btn_step = 1'b0; tick(10);
        total++; if (bus.cycle_cnt !== 8'd1)   begin bad++; $display("FAIL clr_pre got=%0d exp=1", bus.cycle_cnt); end
        bus.btn_step = 1'b1;
        tick(7);
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        total++; if (bus.step_en !== 1'b0)     begin bad++; $display("FAIL clr_suppress got=%0b exp=0", bus.step_en); end
        total++; if (bus.cycle_cnt !== 8'd0)   begin bad++; $display("FAIL clr_cnt got=%0d exp=0", bus.cycle_cnt); end
        total++; if (bus.refresh !== 1'b1)     begin bad++; $display("FAIL clr_refresh got=%0b exp=1", bus.refresh); end
        tick(1);
        total++; if (bus.refresh !== 1'b0 || bus.step_en !== 1'b0) begin
            bad++; $display("FAIL clr_after got=ref%0b/step%0b exp=0/0", bus.refresh, bus.step_en);
        end
        tick(3);
        bus.btn_step = 1'b0;
        tick(12);
        total++; if (step_seen !== c0 + 257)   begin bad++; $display("FAIL clr_steps got=%0d exp=257", step_seen - c0); end
        bus.break_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int c0;
        c0 = step_seen;
        bus.btn_run = 1'b1;
        tick(8);
        bus.btn_run = 1'b0;
        tick(13);
        total++; if (bus.running !== 1'b1 || bus.cycle_cnt !== 8'd1) begin
            bad++; $display("FAIL mid_pre got=run%0b/cnt%0d exp=1/1", bus.running, bus.cycle_cnt);
        end
        rst_n = 1'b0;
        #1;
        total++; if (bus.running !== 1'b0)   begin bad++; $display("FAIL mid_running got=%0b exp=0", bus.running); end
        total++; if (bus.cycle_cnt !== 8'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", bus.cycle_cnt); end
        total++; if (bus.step_en !== 1'b0 || bus.refresh !== 1'b0 || bus.halted !== 1'b0) begin
            bad++; $display("FAIL mid_outs got=%0b%0b%0b exp=000", bus.step_en, bus.refresh, bus.halted);
        end
        tick(3);
        rst_n = 1'b1;
        tick(30);
        total++; if (step_seen !== c0 + 1 || bus.running !== 1'b0) begin
            bad++; $display("FAIL mid_after got=%0d/run%0b exp=1/0", step_seen - c0, bus.running);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        step_seen = 0;
        prev_step = 1'b0;
        rst_n = 1'b0;
        bus.btn_step = 1'b0;
        bus.btn_run = 1'b0;
        bus.clr = 1'b0;
        bus.pc = 32'h0;
        bus.break_pc = 32'h0;
        bus.break_en = 1'b0;
        test_reset();
        test_step_press();
        test_bounce();
        test_run();
        test_breakpoint();
        test_wrap_and_clr();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
